// File: rtl/seq_mem_pkg.sv
// Shared definitions for the 8x8b nibble-write register-file controller:
// request encodings, default widths, FSM state type and request bundle.
package seq_mem_pkg;

  localparam int MEM_ENTRIES = 8;
  localparam int MEM_ADDR_W  = 3;
  localparam int MEM_DATA_W  = 8;
  localparam int MEM_NIB_W   = MEM_DATA_W / 4;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic                  req_type;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_NIB_W-1:0]  nibble_en;
    logic [MEM_DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/seq_mem_resp_buf.sv
// Single-entry val/rdy pipeline register; can accept a new entry in the same
// cycle the held one is drained.
module seq_mem_resp_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq_val,
  output logic         enq_rdy,
  input  logic [W-1:0] enq_data,
  output logic         deq_val,
  input  logic         deq_rdy,
  output logic [W-1:0] deq_data
);

  logic         val_reg;
  logic [W-1:0] data_reg;

  assign enq_rdy  = !val_reg || deq_rdy;
  assign deq_val  = val_reg;
  assign deq_data = data_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      val_reg  <= 1'b0;
      data_reg <= '0;
    end else if (enq_val && enq_rdy) begin
      val_reg  <= 1'b1;
      data_reg <= enq_data;
    end else if (deq_rdy) begin
      val_reg  <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_mem_8x8b_pw_ctrl.sv
// Initiator controller for an 8x8b 1r1w register file with nibble write
// enables: zero-fills after reset, then serves val/rdy read/write requests.
module seq_mem_8x8b_pw_ctrl
  import seq_mem_pkg::*;
#(
  parameter int NUM_ENTRIES = MEM_ENTRIES,
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int NIB_W       = MEM_NIB_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic              req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [NIB_W-1:0]  req_nibble_en,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [NIB_W-1:0]  mem_write_nibble_en,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0] mem_write_data
);

  state_t            state_reg;
  logic [ADDR_W-1:0] init_cnt_reg;
  logic              init_done_reg;
  logic              in_init;
  logic              buf_rdy;
  logic              fire;
  logic              wr_fire;
  logic              rd_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_INIT;
      init_cnt_reg  <= '0;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          init_cnt_reg <= init_cnt_reg + 1'b1;
          if (init_cnt_reg == ADDR_W'(NUM_ENTRIES - 1)) begin
            state_reg     <= ST_RUN;
            init_done_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  assign in_init   = (state_reg == ST_INIT);
  assign init_done = init_done_reg;
  assign req_rdy   = !in_init && buf_rdy;
  assign fire      = req_val && req_rdy;
  assign wr_fire   = fire && (req_type == REQ_WRITE);
  assign rd_fire   = fire && (req_type == REQ_READ);

  // The write port is owned by the zero-fill during INIT, otherwise by a write fire.
  generate
    for (genvar gi = 0; gi < NIB_W; gi++) begin : g_nib_en
      assign mem_write_nibble_en[gi] = in_init || (wr_fire && req_nibble_en[gi]);
    end
  endgenerate

  assign mem_write_addr = in_init ? init_cnt_reg : (wr_fire ? req_addr : '0);
  assign mem_write_data = wr_fire ? req_data : '0;
  assign mem_read_addr  = in_init ? '0 : req_addr;

  seq_mem_resp_buf #(
    .W (DATA_W)
  ) u_resp_buf (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (rd_fire),
    .enq_rdy  (buf_rdy),
    .enq_data (mem_read_data),
    .deq_val  (resp_val),
    .deq_rdy  (resp_rdy),
    .deq_data (resp_data)
  );

endmodule

// File: tb/tb_seq_mem_8x8b_pw_ctrl.sv
// Bench for seq_mem_8x8b_pw_ctrl with a behavioural nibble-write register file
// attached; read results are scoreboarded through a queue of expected data.
module tb_seq_mem_8x8b_pw_ctrl;
  import seq_mem_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_val = 1'b0;
  logic       req_rdy;
  logic       req_type = 1'b0;
  logic [2:0] req_addr = '0;
  logic [1:0] req_nibble_en = '0;
  logic [7:0] req_data = '0;
  logic       resp_val;
  logic       resp_rdy = 1'b0;
  logic [7:0] resp_data;
  logic       init_done;
  logic [2:0] mem_read_addr;
  logic [7:0] mem_read_data;
  logic [1:0] mem_write_nibble_en;
  logic [2:0] mem_write_addr;
  logic [7:0] mem_write_data;

  int total = 0;
  int bad = 0;

  logic [7:0] rf [8];
  logic [7:0] ref_mem [8];
  logic [7:0] exp_q [$];
  bit         model_run;
  int         model_cnt;

  always #5 clk = ~clk;

  seq_mem_8x8b_pw_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .req_val             (req_val),
    .req_rdy             (req_rdy),
    .req_type            (req_type),
    .req_addr            (req_addr),
    .req_nibble_en       (req_nibble_en),
    .req_data            (req_data),
    .resp_val            (resp_val),
    .resp_rdy            (resp_rdy),
    .resp_data           (resp_data),
    .init_done           (init_done),
    .mem_read_addr       (mem_read_addr),
    .mem_read_data       (mem_read_data),
    .mem_write_nibble_en (mem_write_nibble_en),
    .mem_write_addr      (mem_write_addr),
    .mem_write_data      (mem_write_data)
  );

  // Register file: combinational read, nibble-enabled write at posedge.
  assign mem_read_data = rf[mem_read_addr];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (mem_write_nibble_en[i]) rf[mem_write_addr][4*i +: 4] <= mem_write_data[4*i +: 4];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_val = 1'b0;
    resp_rdy = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_resp_val", {31'b0, resp_val}, 32'd0);
    check("rst_resp_data", {24'b0, resp_data}, 32'd0);
    check("rst_init_done", {31'b0, init_done}, 32'd0);
    exp_q.delete();
    model_run = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic cycle(input logic v, input logic t, input logic [2:0] a,
                       input logic [1:0] e, input logic [7:0] d, input logic rr);
    logic exp_rdy;
    @(negedge clk);
    req_val = v;
    req_type = t;
    req_addr = a;
    req_nibble_en = e;
    req_data = d;
    resp_rdy = rr;
    #1;
    exp_rdy = model_run && (exp_q.size() == 0 || rr);
    check("req_rdy", {31'b0, req_rdy}, {31'b0, exp_rdy});
    check("init_done", {31'b0, init_done}, {31'b0, model_run});
    check("resp_val", {31'b0, resp_val}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check("resp_data", {24'b0, resp_data}, {24'b0, exp_q[0]});
      if (rr) void'(exp_q.pop_front());
    end
    if (!model_run) begin
      check("init_wen", {30'b0, mem_write_nibble_en}, 32'h3);
      check("init_waddr", {29'b0, mem_write_addr}, {29'b0, model_cnt[2:0]});
    end else if (v && exp_rdy && t == REQ_WRITE) begin
      check("wr_en", {30'b0, mem_write_nibble_en}, {30'b0, e});
    end else begin
      check("idle_wen", {30'b0, mem_write_nibble_en}, 32'h0);
    end
    if (v && exp_rdy) begin
      if (t == REQ_WRITE) begin
        if (e[0]) ref_mem[a][3:0] = d[3:0];
        if (e[1]) ref_mem[a][7:4] = d[7:4];
      end else begin
        exp_q.push_back(ref_mem[a]);
      end
    end
    if (!model_run) begin
      model_cnt++;
      if (model_cnt == 8) model_run = 1'b1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && exp_q.size() != 0; i++)
      cycle(1'b0, REQ_READ, 3'd0, 2'b00, 8'h00, 1'b1);
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    req_t r;
    logic [7:0] nib_data [4];
    logic [1:0] nib_en [4];
    nib_data[0] = 8'hff; nib_en[0] = 2'b11;
    nib_data[1] = 8'hab; nib_en[1] = 2'b01;
    nib_data[2] = 8'hab; nib_en[2] = 2'b10;
    nib_data[3] = 8'h12; nib_en[3] = 2'b00;

    // Zero-fill: requests held valid are refused for 8 cycles.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, REQ_READ, 3'd0, 2'b00, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, REQ_READ, 3'(i), 2'b00, 8'h00, 1'b1);
    drain();

    // Nibble-enabled writes to addr 3, each read back.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, REQ_WRITE, 3'd3, nib_en[i], nib_data[i], 1'b1);
      cycle(1'b1, REQ_READ, 3'd3, 2'b00, 8'h00, 1'b1);
    end
    drain();
    check("rf3_final", {24'b0, rf[3]}, 32'hab);

    // Backpressure: response held for 5 cycles, then drained and refilled together.
    cycle(1'b1, REQ_READ, 3'd0, 2'b00, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, REQ_READ, 3'd1, 2'b00, 8'h00, 1'b0);
    cycle(1'b1, REQ_READ, 3'd1, 2'b00, 8'h00, 1'b1);
    drain();

    // Streaming writes then back-to-back reads.
    for (int i = 0; i < 8; i++) cycle(1'b1, REQ_WRITE, 3'(i), 2'b11, 8'(i * 8'h22 + 8'h01), 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, REQ_READ, 3'(i), 2'b00, 8'h00, 1'b1);
    drain();
    check("rf7_stream", {24'b0, rf[7]}, 32'hef);

    // Reset with a pending response after writing addr 2.
    cycle(1'b1, REQ_WRITE, 3'd2, 2'b11, 8'h5a, 1'b1);
    cycle(1'b1, REQ_READ, 3'd2, 2'b00, 8'h00, 1'b0);
    cycle(1'b0, REQ_READ, 3'd0, 2'b00, 8'h00, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, REQ_READ, 3'd2, 2'b00, 8'h00, 1'b1);
    cycle(1'b1, REQ_READ, 3'd2, 2'b00, 8'h00, 1'b1);
    drain();

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      r.req_type  = 1'($urandom_range(0, 1));
      r.addr      = 3'($urandom_range(0, 7));
      r.nibble_en = 2'($urandom_range(0, 3));
      r.data      = 8'($urandom_range(0, 255));
      cycle(1'($urandom_range(0, 1)), r.req_type, r.addr, r.nibble_en, r.data,
            1'($urandom_range(0, 1)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
